// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    localparam int WORDCNT_W = 16;

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake and serial output bundle for the bit serializer.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0]     data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic                 shift_en;
    logic                 serial_out;
    logic                 serial_valid;
    logic                 frame_start;
    logic                 busy;
    logic [WORDCNT_W-1:0] words_sent;

    modport master (
        output data_in, data_valid, shift_en,
        input  data_ready, serial_out, serial_valid, frame_start, busy, words_sent
    );

    modport slave (
        input  data_in, data_valid, shift_en,
        output data_ready, serial_out, serial_valid, frame_start, busy, words_sent
    );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with a one-word holding register for gapless streaming.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight; serial_valid low, waiting for an accept
//   SHIFT | sreg being emitted, one bit per shift_en edge
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    ser_state_t           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]     sreg, sreg_nxt;
    logic [WIDTH-1:0]     hold, hold_nxt;
    logic                 hold_full, hold_full_nxt;
    logic                 sout, sout_nxt;
    logic                 svalid, svalid_nxt;
    logic                 fstart, fstart_nxt;
    logic [WORDCNT_W-1:0] word_cnt, word_cnt_nxt;
    logic                 accept;

    // Bit of a word presented at position idx of the frame.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] rev;
        rev = LAST - idx;
        if (MSB_FIRST) pick = w[rev];
        else           pick = w[idx];
    endfunction

    // Ready comes only from the registered hold flag, never from data_valid.
    assign accept           = bus.data_valid && !hold_full;
    assign bus.data_ready   = !hold_full;
    assign bus.serial_out   = sout;
    assign bus.serial_valid = svalid;
    assign bus.frame_start  = fstart;
    assign bus.busy         = (state == SHIFT) || hold_full;
    assign bus.words_sent   = word_cnt;

    // State and datapath registers; reset drops both the in-flight and held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            sout      <= 1'b0;
            svalid    <= 1'b0;
            fstart    <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            sout      <= sout_nxt;
            svalid    <= svalid_nxt;
            fstart    <= fstart_nxt;
            word_cnt  <= word_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sreg_nxt      = sreg;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        sout_nxt      = sout;
        svalid_nxt    = svalid;
        fstart_nxt    = fstart;
        word_cnt_nxt  = word_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt   = bus.data_in;
                    cnt_nxt    = '0;
                    sout_nxt   = pick(bus.data_in, '0);
                    svalid_nxt = 1'b1;
                    fstart_nxt = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.shift_en || cnt != LAST) begin
                    // Stalled or mid-word: a new word can only go to the hold register.
                    if (accept) begin
                        hold_nxt      = bus.data_in;
                        hold_full_nxt = 1'b1;
                    end
                    if (bus.shift_en) begin
                        cnt_nxt    = cnt + 1'b1;
                        sout_nxt   = pick(sreg, cnt + 1'b1);
                        fstart_nxt = 1'b0;
                    end
                end else begin
                    word_cnt_nxt = word_cnt + 1'b1;
                    if (hold_full) begin
                        sreg_nxt      = hold;
                        hold_full_nxt = 1'b0;
                        cnt_nxt       = '0;
                        sout_nxt      = pick(hold, '0);
                        fstart_nxt    = 1'b1;
                    end else if (accept) begin
                        sreg_nxt   = bus.data_in;
                        cnt_nxt    = '0;
                        sout_nxt   = pick(bus.data_in, '0);
                        fstart_nxt = 1'b1;
                    end else begin
                        cnt_nxt    = '0;
                        sout_nxt   = 1'b0;
                        svalid_nxt = 1'b0;
                        fstart_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
